pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the byte address loaded into pc on reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall  input  1  hold the fetch address; from hazard logic.
REQ-005 SHALL have port halt_req  input  1  enter HALT (ecall/ebreak decoded downstream).
REQ-006 SHALL have port br_op  input  3  branch kind: 000 none, 001 beq, 010 bne, 011 blt, 100 bge, 101 bltu, 110 bgeu, 111 unconditional jump.
REQ-007 SHALL have ports eq, sl, slu  input  1 each  ALU compare flags for the resolving instruction: equal, signed-less, unsigned-less.
REQ-008 SHALL have port br_target  input  32  redirect byte address.
REQ-009 SHALL have port next_pc  output  32  combinational address presented to fetch this cycle.
REQ-010 SHALL have port fetch_addr  output  8  next_pc[9:2], the word index into the 256-entry instruction memory.
REQ-011 SHALL have port pc  output  32  registered address of the instruction currently held in fetch.
REQ-012 SHALL have port fetch_valid  output  1  registered; fetch output is a real instruction.
REQ-013 SHALL have port flush  output  1  combinational; kill the wrong-path instruction now in fetch.
REQ-014 SHALL have port halted  output  1  registered; state is HALT.
REQ-015 SHALL have port fetch_count  output  32  registered count of issued fetches.

Function
REQ-016 SHALL evaluate taken = br_op 001:eq, 010:!eq, 011:sl, 100:!sl, 101:slu, 110:!slu, 111:1, 000:0.
REQ-017 SHALL implement two states, RUN and HALT; HALT is left only by reset.
REQ-018 SHALL select next_pc, in priority order: HALT -> pc; taken with br_target[1:0]!=0 -> pc; taken -> br_target; halt_req -> pc; stall -> pc; else pc+4 (mod 2^32).
REQ-019 SHALL assert flush = taken && state==RUN, including the misaligned case.
REQ-020 SHALL give a taken redirect priority over a simultaneous stall and halt_req.
REQ-021 SHALL transition RUN->HALT on the edge where halt_req=1 with no aligned taken redirect, or where taken with br_target[1:0]!=0.
REQ-022 SHALL load pc <= next_pc on every rising edge in RUN; pc is frozen in HALT.
REQ-023 SHALL set fetch_valid on each edge to 1 in RUN when not entering HALT, else 0; a stall leaves fetch_valid unchanged (same address re-read).
REQ-024 SHALL increment fetch_count, saturating at 32'hFFFF_FFFF, on each edge where the state stays RUN and (stall=0 or aligned taken=1).
REQ-025 SHALL ignore next_pc[31:10] in fetch_addr; addresses wrap modulo 1 KiB by truncation.
REQ-026 SHALL register no input combinationally into pc except through next_pc; next_pc-to-pc latency is exactly one edge, matching fetch's one-edge memory read.

Reset
REQ-027 SHALL, while rst_n=0 (asynchronously), force pc=RESET_PC, state=RUN, fetch_valid=0, halted=0, fetch_count=0.
REQ-028 SHALL, during reset, drive next_pc=RESET_PC and flush=0 independent of the other inputs.
REQ-029 SHALL, on reset assertion mid-operation (including in HALT or mid-stall), abandon all state; the first edge after release loads pc=RESET_PC+4 unless stalled or redirected.

Verification
REQ-030 SHALL cover sequential run: release reset, no stall/branch, 4 edges -> pc 0x4,0x8,0xC,0x10; fetch_valid=1 from edge 1; fetch_count=4.
REQ-031 SHALL cover taken beq under stall: pc=0x20, stall=1, br_op=001, eq=1, br_target=0x100 -> flush=1, next_pc=0x100, fetch_addr=0x40; next edge pc=0x100.
REQ-032 SHALL cover not-taken bltu: br_op=101, slu=0, pc=0x40 -> flush=0, next_pc=0x44.
REQ-033 SHALL cover misaligned jump: br_op=111, br_target=0x102 -> flush=1, next edge halted=1, fetch_valid=0, pc unchanged; stays put for 10 edges despite branches.
REQ-034 SHALL cover stall hold: stall=1 for 3 edges at pc=0x8 -> pc stays 0x8, fetch_count unchanged, fetch_valid stays 1.
REQ-035 SHALL cover async reset in HALT: drop rst_n between edges -> outputs reach reset values before the next edge; fetch_count saturation checked by preloading 32'hFFFF_FFFF via force.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter and fetch sequencer: resolves branches, drives the
// instruction-memory word index and tracks run/halt and issued fetches.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        halt_req,
  input  logic [2:0]  br_op,
  input  logic        eq,
  input  logic        sl,
  input  logic        slu,
  input  logic [31:0] br_target,
  output logic [31:0] next_pc,
  output logic [7:0]  fetch_addr,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        flush,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] count_reg;
  logic        fetch_valid_reg;

  logic [31:0] pc_next;
  logic        taken;
  logic        misaligned;
  logic        redirect;
  logic        enter_halt;
  logic        advance;

  always_comb begin
    taken = 1'b0;
    case (br_op)
      3'b001:  taken = eq;
      3'b010:  taken = !eq;
      3'b011:  taken = sl;
      3'b100:  taken = !sl;
      3'b101:  taken = slu;
      3'b110:  taken = !slu;
      3'b111:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign misaligned = (br_target[1:0] != 2'b00);
  assign redirect   = taken && !misaligned;

  // A misaligned taken target traps: the core halts instead of fetching it.
  assign enter_halt = (state_reg == RUN) &&
                      ((taken && misaligned) || (halt_req && !redirect));
  assign advance    = (state_reg == RUN) && !enter_halt && (!stall || redirect);

  always_comb begin
    pc_next = pc_reg + 32'd4;
    if (!rst_n)                   pc_next = RESET_PC;
    else if (state_reg == HALT)   pc_next = pc_reg;
    else if (taken && misaligned) pc_next = pc_reg;
    else if (taken)               pc_next = br_target;
    else if (halt_req)            pc_next = pc_reg;
    else if (stall)               pc_next = pc_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= RUN;
      pc_reg          <= RESET_PC;
      fetch_valid_reg <= 1'b0;
      count_reg       <= 32'd0;
    end else if (state_reg == RUN) begin
      pc_reg <= pc_next;
      if (enter_halt) begin
        state_reg       <= HALT;
        fetch_valid_reg <= 1'b0;
      end else if (!stall || redirect) begin
        fetch_valid_reg <= 1'b1;
      end
      if (advance && (count_reg != 32'hFFFF_FFFF)) begin
        count_reg <= count_reg + 32'd1;
      end
    end
  end

  assign next_pc     = pc_next;
  assign fetch_addr  = pc_next[9:2];
  assign pc          = pc_reg;
  assign fetch_valid = fetch_valid_reg;
  assign flush       = rst_n && taken && (state_reg == RUN);
  assign halted      = (state_reg == HALT);
  assign fetch_count = count_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a driver feeds directed and random cycles to a
// reference model; a monitor checks the DUT against the queued expectations.
module tb_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic [2:0]  br_op = 3'b000;
  logic        eq = 1'b0;
  logic        sl = 1'b0;
  logic        slu = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic [31:0] next_pc;
  logic [7:0]  fetch_addr;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        halted;
  logic [31:0] fetch_count;

  pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .halt_req(halt_req),
    .br_op(br_op), .eq(eq), .sl(sl), .slu(slu), .br_target(br_target),
    .next_pc(next_pc), .fetch_addr(fetch_addr), .pc(pc),
    .fetch_valid(fetch_valid), .flush(flush), .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a_next_pc;
    logic [7:0]  a_faddr;
    logic        a_flush;
    logic [31:0] a_pc;
    logic        a_fv;
    logic        a_halted;
    logic [31:0] a_cnt;
    logic [31:0] b_pc;
    logic        b_fv;
    logic        b_halted;
    logic [31:0] b_cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Reference model state (architectural view only).
  logic [31:0]     m_pc = RST_PC;
  bit              m_halted = 0;
  bit              m_fv = 0;
  longint unsigned m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit branch_taken(input logic [2:0] op, input bit e, input bit s, input bit su);
    case (op)
      3'd1: return e;
      3'd2: return !e;
      3'd3: return s;
      3'd4: return !s;
      3'd5: return su;
      3'd6: return !su;
      3'd7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input bit r, input bit st, input bit hr, input logic [2:0] op,
                      input bit e, input bit s, input bit su, input logic [31:0] tgt,
                      input bit preload = 0);
    exp_t it;
    bit t, mis, go_halt, hold;
    @(negedge clk);
    rst_n = r; stall = st; halt_req = hr; br_op = op;
    eq = e; sl = s; slu = su; br_target = tgt;
    if (preload) begin
      force dut.count_reg = 32'hFFFF_FFFF;
      release dut.count_reg;
      m_cnt = 64'hFFFF_FFFF;
    end
    if (!r) begin
      m_pc = RST_PC; m_halted = 0; m_fv = 0; m_cnt = 0;
    end
    it.a_pc = m_pc; it.a_fv = m_fv; it.a_halted = m_halted; it.a_cnt = m_cnt[31:0];
    t   = branch_taken(op, e, s, su);
    mis = (tgt % 4) != 0;
    if (!r) begin
      it.a_next_pc = RST_PC;
      it.a_flush   = 0;
    end else if (m_halted) begin
      it.a_next_pc = m_pc;
      it.a_flush   = 0;
    end else begin
      it.a_flush = t;
      if (t && !mis)           it.a_next_pc = tgt;
      else if (t || hr || st)  it.a_next_pc = m_pc;
      else                     it.a_next_pc = m_pc + 32'd4;
      go_halt = (t && mis) || (hr && !(t && !mis));
      hold    = st && !(t && !mis);
      m_pc = it.a_next_pc;
      if (go_halt) begin
        m_halted = 1; m_fv = 0;
      end else begin
        if (!hold) begin
          m_fv = 1;
          if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
      end
    end
    it.a_faddr = 8'((it.a_next_pc % 1024) / 4);
    it.b_pc = m_pc; it.b_fv = m_fv; it.b_halted = m_halted; it.b_cnt = m_cnt[31:0];
    sb.push_back(it);
  endtask

  // Monitor: combinational and async-reset view between edges, registered view after the edge.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        it = sb.pop_front();
        chk("next_pc", next_pc, it.a_next_pc);
        chk("fetch_addr", 32'(fetch_addr), 32'(it.a_faddr));
        chk("flush", 32'(flush), 32'(it.a_flush));
        chk("pc_pre", pc, it.a_pc);
        chk("fetch_valid_pre", 32'(fetch_valid), 32'(it.a_fv));
        chk("halted_pre", 32'(halted), 32'(it.a_halted));
        chk("fetch_count_pre", fetch_count, it.a_cnt);
        @(posedge clk);
        #1;
        chk("pc", pc, it.b_pc);
        chk("fetch_valid", 32'(fetch_valid), 32'(it.b_fv));
        chk("halted", 32'(halted), 32'(it.b_halted));
        chk("fetch_count", fetch_count, it.b_cnt);
        $display("cycle t=%0t rst_n=%0b stall=%0b halt_req=%0b br_op=%0d tgt=%h next_pc=%h pc=%h fv=%0b halted=%0b cnt=%h",
                 $time, rst_n, stall, halt_req, br_op, br_target, next_pc, pc, fetch_valid, halted, fetch_count);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset then sequential run to 0x20.
    step(0, 0, 0, 3'd0, 0, 0, 0, 32'd0);
    step(0, 1, 1, 3'd7, 1, 1, 1, 32'h0000_0200);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 3'd0, 0, 0, 0, 32'd0);
    // Taken beq under stall, then jump to 0x40 and a not-taken bltu.
    step(1, 1, 0, 3'd1, 1, 0, 0, 32'h0000_0100);
    step(1, 0, 0, 3'd7, 0, 0, 0, 32'h0000_0040);
    step(1, 0, 0, 3'd5, 1, 1, 0, 32'h0000_0300);
    // Stall hold at 0x8.
    step(0, 0, 0, 3'd0, 0, 0, 0, 32'd0);
    step(1, 0, 0, 3'd0, 0, 0, 0, 32'd0);
    step(1, 0, 0, 3'd0, 0, 0, 0, 32'd0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 3'd0, 0, 0, 0, 32'd0);
    // Misaligned jump halts; branches afterwards are ignored.
    step(1, 0, 0, 3'd7, 0, 0, 0, 32'h0000_0102);
    for (int i = 0; i < 10; i++)
      step(1, 1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), $urandom & 32'hFFFF_FFFC);
    // Async reset while halted, then release.
    step(0, 0, 0, 3'd7, 0, 0, 0, 32'h0000_0400);
    step(1, 0, 0, 3'd0, 0, 0, 0, 32'd0);
    // Saturation of the fetch counter.
    step(1, 0, 0, 3'd0, 0, 0, 0, 32'd0, 1);
    step(1, 0, 0, 3'd0, 0, 0, 0, 32'd0);
    // Randomized traffic with occasional resets, halts and traps.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = $urandom;
      if ($urandom_range(0, 15) != 0) tgt[1:0] = 2'b00;
      step($urandom_range(0, 99) >= 4, $urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0, 3'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), tgt);
    end
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
